mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit sequencer for the 5-stage pipeline. Sits in EX beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and owns the HI/LO architectural registers.
- Models fixed multi-cycle latency with a busy counter, so the hazard unit can stall MD-dependent instructions.
- Supports cancellation of an in-flight operation on exception flush.

Parameters:
MUL_CYCLES, 5, busy duration of MULT/MULTU (>=1)
DIV_CYCLES, 10, busy duration of DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request valid this cycle
mdop  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
op1  input  32  rs operand (dividend / multiplicand / MT source)
op2  input  32  rt operand (divisor / multiplier)
cancel  input  1  abort in-flight MUL/DIV (exception flush)
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  MUL/DIV in progress
done  output  1  one-cycle pulse: HI/LO just committed by MUL/DIV

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high; it forces hi=0, lo=0, busy=0, done=0, counter=0 and state IDLE immediately, including mid-operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter>0.
- IDLE, start=1, cancel=0, mdop MULT/MULTU/DIV/DIVU:
  - At the edge, compute the result into shadow registers res_hi/res_lo.
  - Load counter with MUL_CYCLES or DIV_CYCLES. Enter RUN.
  - hi/lo are unchanged during RUN.
- RUN: counter decrements each edge.
  - On the edge where counter==1: copy shadows to hi/lo, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles following the start edge.
  - done=1 for the single cycle after commit; it is registered.
- IDLE, start=1, mdop MTHI/MTLO: hi (or lo) <= op1 at the edge. No busy, no done.
- start with mdop NONE/7: no effect.
- start while busy: ignored, no state change. The pipeline must stall on (busy | start&mdop in 1..4); stalling is not this block's job.
- cancel while RUN: at the next edge return to IDLE, busy=0, counter=0, hi/lo unchanged, no done.
- cancel and start in the same IDLE cycle: cancel wins and start is ignored, including MTHI/MTLO.
- cancel while IDLE without start: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64 bit. MULTU: unsigned. {hi,lo} = product.
  - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Divide by zero (DIV or DIVU): still runs DIV_CYCLES and asserts done, but hi/lo keep their prior values.
- Operands are sampled only at the start edge. Later changes to op1/op2 have no effect.

Test Plan:
- Reset, then MULT op1=0xFFFFFFFE(-2) op2=3 -> busy high 5 cycles; after the 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses one cycle.
- MULTU op1=0xFFFFFFFF op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV op1=-7 op2=2 -> busy 10 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU 7/0 with prior hi=0x11, lo=0x22 -> done pulses after 10 cycles, hi/lo stay 0x11/0x22.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo updated one edge each, busy never asserted. MTHI with start raised during RUN -> ignored, hi unchanged.
- DIV started, cancel at busy cycle 4 -> busy falls after that edge, hi/lo unchanged, no done. A new MULT the next cycle completes normally.
- Assert reset asynchronously (between edges) at busy cycle 3 of a MULT -> hi=lo=0 and busy=0 immediately; no commit follows.

Source files
------------

// File: rtl/mdu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide sequencer for EX. Owns HI/LO and exposes a
//                fixed-latency busy window so dependent instructions can stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdop,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        cancel,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int c_cw         = $clog2(c_max_cycles + 1);

   localparam logic [c_cw-1:0] c_mul_cnt = c_cw'(MUL_CYCLES);
   localparam logic [c_cw-1:0] c_div_cnt = c_cw'(DIV_CYCLES);
   localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

   localparam logic [2:0] c_op_mult  = 3'd1;
   localparam logic [2:0] c_op_multu = 3'd2;
   localparam logic [2:0] c_op_div   = 3'd3;
   localparam logic [2:0] c_op_divu  = 3'd4;
   localparam logic [2:0] c_op_mthi  = 3'd5;
   localparam logic [2:0] c_op_mtlo  = 3'd6;

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_run  = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [c_cw-1:0] r_count;
   logic [31:0]     r_hi;
   logic [31:0]     r_lo;
   logic [31:0]     r_res_hi;
   logic [31:0]     r_res_lo;
   logic            r_commit;
   logic            r_done;

   logic            w_req;
   logic            w_launch;
   logic            w_mul_sgn;
   logic            w_div_sgn;
   logic [63:0]     w_mul_a;
   logic [63:0]     w_mul_b;
   logic [63:0]     w_prod;
   logic [31:0]     w_dvd;
   logic [31:0]     w_dvs;
   logic [31:0]     w_quot_mag;
   logic [31:0]     w_rem_mag;
   logic [31:0]     w_quot;
   logic [31:0]     w_rem;

   // Cancel in the same cycle as a request suppresses it entirely.
   assign w_req    = start && !cancel;
   assign w_launch = w_req && (r_state == c_st_idle) &&
                     ((mdop == c_op_mult) || (mdop == c_op_multu) ||
                      (mdop == c_op_div)  || (mdop == c_op_divu));

   // One 64x64 multiplier serves both flavours; low 64 bits are exact either way.
   assign w_mul_sgn = (mdop == c_op_mult);
   assign w_mul_a   = {{32{w_mul_sgn & op1[31]}}, op1};
   assign w_mul_b   = {{32{w_mul_sgn & op2[31]}}, op2};
   assign w_prod    = w_mul_a * w_mul_b;

   // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is
   // the correct unsigned magnitude, so the overflow case needs no special path.
   assign w_div_sgn  = (mdop == c_op_div);
   assign w_dvd      = (w_div_sgn && op1[31]) ? (32'd0 - op1) : op1;
   assign w_dvs      = (op2 == 32'd0) ? 32'd1 :
                       ((w_div_sgn && op2[31]) ? (32'd0 - op2) : op2);
   assign w_quot_mag = w_dvd / w_dvs;
   assign w_rem_mag  = w_dvd % w_dvs;
   assign w_quot     = (w_div_sgn && (op1[31] ^ op2[31])) ? (32'd0 - w_quot_mag) : w_quot_mag;
   assign w_rem      = (w_div_sgn && op1[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_launch) begin
               w_state_nxt = c_st_run;
            end
         end
         c_st_run: begin
            if (cancel || (r_count == c_cnt_one)) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      busy = (r_state == c_st_run);
      done = r_done;
      hi   = r_hi;
      lo   = r_lo;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count  <= '0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_res_hi <= 32'd0;
         r_res_lo <= 32'd0;
         r_commit <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == c_st_idle) begin
            if (w_req) begin
               case (mdop)
                  c_op_mult, c_op_multu: begin
                     r_res_hi <= w_prod[63:32];
                     r_res_lo <= w_prod[31:0];
                     r_commit <= 1'b1;
                     r_count  <= c_mul_cnt;
                  end
                  c_op_div, c_op_divu: begin
                     r_res_hi <= w_rem;
                     r_res_lo <= w_quot;
                     // Divide by zero still occupies the unit but leaves HI/LO alone.
                     r_commit <= (op2 != 32'd0);
                     r_count  <= c_div_cnt;
                  end
                  c_op_mthi: r_hi <= op1;
                  c_op_mtlo: r_lo <= op1;
                  default: ;
               endcase
            end
         end else begin
            if (cancel) begin
               r_count <= '0;
            end else begin
               r_count <= r_count - c_cnt_one;
               if (r_count == c_cnt_one) begin
                  r_done <= 1'b1;
                  if (r_commit) begin
                     r_hi <= r_res_hi;
                     r_lo <= r_res_lo;
                  end
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Directed and random stimulus for mdu_ctrl against a
//                cycle-level behavioural model of HI/LO and the busy window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

   localparam int c_mul = 5;
   localparam int c_div = 10;

   localparam logic [2:0] c_none  = 3'd0;
   localparam logic [2:0] c_mult  = 3'd1;
   localparam logic [2:0] c_multu = 3'd2;
   localparam logic [2:0] c_div_op  = 3'd3;
   localparam logic [2:0] c_divu  = 3'd4;
   localparam logic [2:0] c_mthi  = 3'd5;
   localparam logic [2:0] c_mtlo  = 3'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        cancel;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   // Reference state: architectural HI/LO, remaining busy cycles, pending result.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   int          m_rem;
   bit          m_commit;
   bit          m_done;

   mdu_ctrl #(.MUL_CYCLES(c_mul), .DIV_CYCLES(c_div)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdop   (mdop),
      .op1    (op1),
      .op2    (op2),
      .cancel (cancel),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
      m_rem = 0; m_commit = 0; m_done = 0;
   endtask

   task automatic model_step(input bit s, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit c);
      longint      sa, sb, q, r;
      logic [63:0] p;
      m_done = 0;
      if (m_rem > 0) begin
         if (c) begin
            m_rem = 0;
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_done = 1;
               if (m_commit) begin
                  m_hi = m_phi;
                  m_lo = m_plo;
               end
            end
         end
      end else if (s && !c) begin
         case (op)
            c_mult: begin
               sa = longint'($signed(a)); sb = longint'($signed(b));
               p = 64'(sa * sb);
               m_phi = p[63:32]; m_plo = p[31:0]; m_commit = 1; m_rem = c_mul;
            end
            c_multu: begin
               p = 64'(a) * 64'(b);
               m_phi = p[63:32]; m_plo = p[31:0]; m_commit = 1; m_rem = c_mul;
            end
            c_div_op: begin
               sa = longint'($signed(a)); sb = longint'($signed(b));
               if (b != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_plo = q[31:0]; m_phi = r[31:0];
               end
               m_commit = (b != 0); m_rem = c_div;
            end
            c_divu: begin
               sa = longint'(a); sb = longint'(b);
               if (b != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_plo = q[31:0]; m_phi = r[31:0];
               end
               m_commit = (b != 0); m_rem = c_div;
            end
            c_mthi: m_hi = a;
            c_mtlo: m_lo = a;
            default: ;
         endcase
      end
   endtask

   // One cycle: compare outputs of the previous edge, then drive the next inputs.
   task automatic cyc(input bit s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit c);
      @(negedge clk);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
      chk("done", {31'b0, done}, {31'b0, m_done});
      start = s; mdop = op; op1 = a; op2 = b; cancel = c;
      model_step(s, op, a, b, c);
   endtask

   // Idle cycles scramble the operand buses to show they are not resampled.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; mdop = c_none; op1 = 0; op2 = 0; cancel = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // MULT -2 * 3
      cyc(1, c_mult, 32'hFFFF_FFFE, 32'd3, 0);
      idle(6);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);
      chk("mult_done", {31'b0, done}, 32'd1);

      // MULTU max * max
      cyc(1, c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      idle(6);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);

      // DIV -7 / 2
      cyc(1, c_div_op, 32'hFFFF_FFF9, 32'd2, 0);
      idle(11);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      // DIVU by zero keeps prior HI/LO
      cyc(1, c_mthi, 32'h11, 32'd0, 0);
      cyc(1, c_mtlo, 32'h22, 32'd0, 0);
      cyc(1, c_divu, 32'd7, 32'd0, 0);
      idle(11);
      chk("div0_hi", hi, 32'h11);
      chk("div0_lo", lo, 32'h22);
      chk("div0_done", {31'b0, done}, 32'd1);

      // Back-to-back MTHI / MTLO
      cyc(1, c_mthi, 32'hDEAD_BEEF, 32'd0, 0);
      cyc(1, c_mtlo, 32'h1234_5678, 32'd0, 0);
      idle(1);
      chk("mt_hi", hi, 32'hDEAD_BEEF);
      chk("mt_lo", lo, 32'h1234_5678);
      chk("mt_busy", {31'b0, busy}, 32'd0);

      // MTHI while busy is ignored
      cyc(1, c_mult, 32'd2, 32'd3, 0);
      cyc(1, c_mthi, 32'hAAAA_AAAA, 32'd0, 0);
      idle(1);
      chk("busy_mthi_hi", hi, 32'hDEAD_BEEF);
      idle(4);
      chk("mult2_hi", hi, 32'd0);
      chk("mult2_lo", lo, 32'd6);

      // Cancel DIV in busy cycle 4, then a fresh MULT
      cyc(1, c_div_op, 32'd100, 32'd7, 0);
      idle(3);
      cyc(0, c_none, 32'd0, 32'd0, 1);
      idle(1);
      chk("cancel_busy", {31'b0, busy}, 32'd0);
      chk("cancel_lo", lo, 32'd6);
      chk("cancel_done", {31'b0, done}, 32'd0);
      cyc(1, c_mult, 32'd7, 32'd9, 0);
      idle(6);
      chk("after_cancel_lo", lo, 32'd63);
      chk("after_cancel_done", {31'b0, done}, 32'd1);

      // Cancel beats MTHI in the same idle cycle
      cyc(1, c_mthi, 32'h5555_5555, 32'd0, 1);
      idle(1);
      chk("cancel_mthi_hi", hi, 32'd0);

      // Signed overflow divide
      cyc(1, c_div_op, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      idle(11);
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'd0);

      // Asynchronous reset in busy cycle 3 of a MULT
      cyc(1, c_mthi, 32'hCAFE_F00D, 32'd0, 0);
      cyc(1, c_mult, 32'd5, 32'd5, 0);
      idle(2);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      model_step(start, mdop, op1, op2, cancel);
      idle(8);
      chk("arst_nocommit_lo", lo, 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             pick_operand(), pick_operand(), ($urandom_range(0, 15) == 0));
      end
      idle(c_div + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
